// File: rtl/pipe_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// Holds forwarding-select encodings, FSM states, the PC register index
// and the shadow-pipeline entry type used by the controller and matcher.
package pipe_pkg;

  localparam int RD_W   = 4;
  localparam int PC_REG = 15;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_SQUASH = 2'd2
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            rf_e;
    logic            load;
  } shadow_t;

  // A source depends on a stage when the stage holds a live register write
  // to that index, the ID instruction really reads it, and it is not the PC.
  function automatic logic stage_match(input shadow_t s, input logic [RD_W-1:0] src,
                                       input logic use_bit, input logic [RD_W-1:0] pc_idx);
    return s.valid && s.rf_e && (s.rd == src) && use_bit && (src != pc_idx);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID-stage source register against the EX, MEM and WB shadow
// entries. Reports a hit per stage ({wb, mem, ex}) and the priority forward
// select (nearest producer wins). Honours macro HAZARD_FWD_EN: when it is
// undefined the forward select is tied to the register-file path.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int REG_W  = RD_W,
  parameter int PC_REG = pipe_pkg::PC_REG
) (
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  shadow_t          ex_s,
  input  shadow_t          mem_s,
  input  shadow_t          wb_s,
  output logic [2:0]       hit,
  output logic [1:0]       sel
);

  localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_REG);

  // Per-stage dependency test followed by the EX > MEM > WB priority select.
  always_comb begin
    hit[0] = stage_match(ex_s,  src, use_src, PC_IDX);
    hit[1] = stage_match(mem_s, src, use_src, PC_IDX);
    hit[2] = stage_match(wb_s,  src, use_src, PC_IDX);
`ifdef HAZARD_FWD_EN
    if (hit[0])      sel = FWD_EX;
    else if (hit[1]) sel = FWD_MEM;
    else if (hit[2]) sel = FWD_WB;
    else             sel = FWD_RF;
`else
    sel = FWD_RF;
`endif
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Keeps a shadow copy of EX/MEM/WB destination info, detects load-use
// (or, without forwarding, any RAW) hazards, squashes on taken branches,
// and drives PC/IF-ID enables, the bubble mux and EX forwarding selects.
// Macro HAZARD_FWD_EN: defined = forwarding with load-use stalls only;
// undefined = no forwarding, any pending producer stalls ID.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W  = RD_W,
  parameter int PC_REG = pipe_pkg::PC_REG,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rd,
  input  logic             id_rf_e,
  input  logic             id_load,
  input  logic             id_branch_taken,
  output logic             pc_e,
  output logic             ifid_e,
  output logic             ifid_clr,
  output logic             ctrl_nop_s,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_c,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t     state;
  shadow_t    ex_s, mem_s, wb_s;
  logic [2:0] hit_a, hit_b, hit_c;
  logic [1:0] sel_a, sel_b, sel_c;
  logic [2:0] stall_mask;
  logic       hazard;

  hazard_match #(.REG_W(REG_W), .PC_REG(PC_REG)) u_match_rn (
    .src(id_rn), .use_src(id_use_rn), .ex_s(ex_s), .mem_s(mem_s), .wb_s(wb_s),
    .hit(hit_a), .sel(sel_a)
  );

  hazard_match #(.REG_W(REG_W), .PC_REG(PC_REG)) u_match_rm (
    .src(id_rm), .use_src(id_use_rm), .ex_s(ex_s), .mem_s(mem_s), .wb_s(wb_s),
    .hit(hit_b), .sel(sel_b)
  );

  hazard_match #(.REG_W(REG_W), .PC_REG(PC_REG)) u_match_rd (
    .src(id_rd), .use_src(id_use_rd), .ex_s(ex_s), .mem_s(mem_s), .wb_s(wb_s),
    .hit(hit_c), .sel(sel_c)
  );

  // Which stage hits force a stall: only a load sitting in EX when forwarding
  // exists, otherwise any producer still in flight.
  always_comb begin
`ifdef HAZARD_FWD_EN
    stall_mask = {1'b0, 1'b0, ex_s.load};
`else
    stall_mask = 3'b111;
`endif
    hazard = |((hit_a | hit_b | hit_c) & stall_mask);
  end

  // Pipeline control outputs react in the same cycle as the ID instruction,
  // so they are decoded from the hazard and reset rather than the state reg.
  always_comb begin
    pc_e       = 1'b1;
    ifid_e     = 1'b1;
    ifid_clr   = 1'b0;
    ctrl_nop_s = 1'b0;
    fwd_a      = sel_a;
    fwd_b      = sel_b;
    fwd_c      = sel_c;
    if (reset) begin
      pc_e       = 1'b0;
      ifid_e     = 1'b0;
      ifid_clr   = 1'b1;
      ctrl_nop_s = 1'b1;
      fwd_a      = FWD_RF;
      fwd_b      = FWD_RF;
      fwd_c      = FWD_RF;
    end else if (hazard) begin
      pc_e       = 1'b0;
      ifid_e     = 1'b0;
      ctrl_nop_s = 1'b1;
    end else if (id_branch_taken) begin
      ifid_clr   = 1'b1;
    end
  end

  // FSM, shadow pipeline advance and saturating stall counter; a bubble or
  // the squashed slot after a clear enters EX as an invalid entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      ex_s      <= '0;
      mem_s     <= '0;
      wb_s      <= '0;
      stall_cnt <= '0;
    end else begin
      if (hazard)               state <= ST_STALL;
      else if (id_branch_taken) state <= ST_SQUASH;
      else                      state <= ST_RUN;

      wb_s  <= mem_s;
      mem_s <= ex_s;
      if (hazard || (state == ST_SQUASH)) begin
        ex_s <= '0;
      end else begin
        ex_s.valid <= 1'b1;
        ex_s.rd    <= id_rd;
        ex_s.rf_e  <= id_rf_e;
        ex_s.load  <= id_load;
      end

      if (hazard && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl. The reference model keeps a
// queue of the instructions that entered EX in recent cycles and derives
// stalls and forward distances from it. Honours macro HAZARD_FWD_EN.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  id_rn, id_rm, id_rd;
  logic        id_use_rn, id_use_rm, id_use_rd, id_rf_e, id_load, id_branch_taken;
  logic        pc_e, ifid_e, ifid_clr, ctrl_nop_s;
  logic [1:0]  fwd_a, fwd_b, fwd_c;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
    .id_rf_e(id_rf_e), .id_load(id_load), .id_branch_taken(id_branch_taken),
    .pc_e(pc_e), .ifid_e(ifid_e), .ifid_clr(ifid_clr), .ctrl_nop_s(ctrl_nop_s),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [3:0] rn, rm, rd;
    logic use_rn, use_rm, use_rd, rf_e, load, br;
  } instr_t;

  typedef struct packed {
    logic   valid;
    instr_t ins;
  } slot_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic        pc_e, ifid_e, ifid_clr, nop;
    logic [1:0]  fa, fb, fc;
    logic [15:0] cnt;
    logic        cnt_known;
  } exp_t;

  slot_t  inflight[$];
  exp_t   expq[$];
  int     errors = 0;
  int     checks = 0;
  int     model_cnt = 0;
  bit     cnt_known = 1'b0;
  bit     clr_prev = 1'b0;
  int     cyc = 0;
  instr_t nop_i = '0;

  function automatic instr_t mk(input int rn, input int rm, input int rd,
                                input bit urn, input bit urm, input bit urd,
                                input bit rfe, input bit ld, input bit br);
    instr_t i;
    i.rn = 4'(rn); i.rm = 4'(rm); i.rd = 4'(rd);
    i.use_rn = urn; i.use_rm = urm; i.use_rd = urd;
    i.rf_e = rfe; i.load = ld; i.br = br;
    return i;
  endfunction

  // Distance (1 = EX, 2 = MEM, 3 = WB) to the youngest in-flight writer of r.
  function automatic int nearest(input logic [3:0] r, input logic u);
    for (int k = 0; k < inflight.size(); k++) begin
      if (inflight[k].valid && inflight[k].ins.rf_e && inflight[k].ins.rd == r &&
          u && r != 4'd15)
        return k + 1;
    end
    return 0;
  endfunction

  task automatic applyStimulus(input instr_t ins, input logic rst, output bit stalled);
    exp_t e;
    int   da, db, dc;
    bit   stall;
    @(posedge clk);
    #1;
    cyc++;
    reset = rst;
    id_rn = ins.rn; id_rm = ins.rm; id_rd = ins.rd;
    id_use_rn = ins.use_rn; id_use_rm = ins.use_rm; id_use_rd = ins.use_rd;
    id_rf_e = ins.rf_e; id_load = ins.load; id_branch_taken = ins.br;

    da = nearest(ins.rn, ins.use_rn);
    db = nearest(ins.rm, ins.use_rm);
    dc = nearest(ins.rd, ins.use_rd);
`ifdef HAZARD_FWD_EN
    stall = (da == 1 || db == 1 || dc == 1) && inflight[0].ins.load;
`else
    stall = (da != 0 || db != 0 || dc != 0);
    da = 0; db = 0; dc = 0;
`endif
    e.cyc = 32'(cyc);
    e.cnt = 16'(model_cnt);
    e.cnt_known = cnt_known;
    e.fa = 2'(da); e.fb = 2'(db); e.fc = 2'(dc);
    if (rst) begin
      e.pc_e = 0; e.ifid_e = 0; e.ifid_clr = 1; e.nop = 1;
      e.fa = 0; e.fb = 0; e.fc = 0;
    end else if (stall) begin
      e.pc_e = 0; e.ifid_e = 0; e.ifid_clr = 0; e.nop = 1;
    end else begin
      e.pc_e = 1; e.ifid_e = 1; e.ifid_clr = ins.br; e.nop = 0;
    end
    expq.push_back(e);

    if (rst) begin
      inflight.delete();
      model_cnt = 0;
      cnt_known = 1'b1;
      clr_prev  = 1'b0;
    end else begin
      slot_t s;
      s.valid = !stall && !clr_prev;
      s.ins   = ins;
      inflight.push_front(s);
      if (inflight.size() > 3) void'(inflight.pop_back());
      if (stall && model_cnt < 65535) model_cnt++;
      clr_prev = ins.br && !stall;
    end
    stalled = stall && !rst;
  endtask

  task automatic checkOutput();
    exp_t e;
    bit   bad;
    e = expq.pop_front();
    checks++;
    bad = (pc_e !== e.pc_e) || (ifid_e !== e.ifid_e) || (ifid_clr !== e.ifid_clr) ||
          (ctrl_nop_s !== e.nop) || (fwd_a !== e.fa) || (fwd_b !== e.fb) ||
          (fwd_c !== e.fc) || (e.cnt_known && (stall_cnt !== e.cnt));
    if (bad) begin
      errors++;
      $display("[TB] FAIL cycle%0d ctrl: got pc_e=%b ifid_e=%b clr=%b nop=%b fwd=%b/%b/%b cnt=%0d, want pc_e=%b ifid_e=%b clr=%b nop=%b fwd=%b/%b/%b cnt=%0d",
               e.cyc, pc_e, ifid_e, ifid_clr, ctrl_nop_s, fwd_a, fwd_b, fwd_c, stall_cnt,
               e.pc_e, e.ifid_e, e.ifid_clr, e.nop, e.fa, e.fb, e.fc, e.cnt);
    end
  endtask

  // Issue an instruction, holding it in ID while the model says it stalls.
  task automatic runInstr(input instr_t ins);
    bit s;
    int n = 0;
    do begin
      applyStimulus(ins, 1'b0, s);
      n++;
    end while (s && n < 6);
  endtask

  function automatic instr_t randInstr();
    instr_t i;
    int     v;
    v = int'($urandom_range(0, 4)); i.rn = (v == 4) ? 4'd15 : 4'(v);
    v = int'($urandom_range(0, 4)); i.rm = (v == 4) ? 4'd15 : 4'(v);
    v = int'($urandom_range(0, 4)); i.rd = (v == 4) ? 4'd15 : 4'(v);
    i.use_rn = 1'($urandom_range(0, 1));
    i.use_rm = 1'($urandom_range(0, 1));
    i.use_rd = ($urandom_range(0, 3) == 0);
    i.rf_e   = 1'($urandom_range(0, 1));
    i.load   = i.rf_e && ($urandom_range(0, 2) == 0);
    i.br     = ($urandom_range(0, 7) == 0);
    if ($urandom_range(0, 9) == 0) i = '0;
    return i;
  endfunction

  // Monitor: the controller presents its outputs every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (expq.size() > 0) checkOutput();
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit s;
    reset = 1'b1;
    id_rn = 0; id_rm = 0; id_rd = 0;
    id_use_rn = 0; id_use_rm = 0; id_use_rd = 0;
    id_rf_e = 0; id_load = 0; id_branch_taken = 0;

    $display("[TB] reset and idle");
    applyStimulus(nop_i, 1'b1, s);
    applyStimulus(nop_i, 1'b1, s);
    runInstr(nop_i);

    $display("[TB] ALU back-to-back dependency");
    runInstr(mk(2, 0, 1, 1, 0, 0, 1, 0, 0));
    runInstr(mk(1, 3, 2, 1, 1, 0, 1, 0, 0));
    repeat (3) runInstr(nop_i);

    $display("[TB] load-use");
    runInstr(mk(0, 0, 4, 0, 0, 0, 1, 1, 0));
    runInstr(mk(4, 4, 5, 1, 1, 0, 1, 0, 0));
    repeat (3) runInstr(nop_i);

    $display("[TB] store data two slots back, PC source");
    runInstr(mk(0, 0, 6, 0, 0, 0, 1, 0, 0));
    runInstr(nop_i);
    runInstr(mk(7, 0, 6, 1, 0, 1, 0, 0, 0));
    runInstr(mk(0, 0, 15, 0, 0, 0, 1, 0, 0));
    runInstr(mk(15, 15, 8, 1, 1, 0, 1, 0, 0));
    repeat (3) runInstr(nop_i);

    $display("[TB] taken branch, alone and with load-use");
    runInstr(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    runInstr(nop_i);
    runInstr(mk(0, 0, 4, 0, 0, 0, 1, 1, 0));
    runInstr(mk(4, 0, 14, 1, 0, 0, 1, 0, 1));
    repeat (3) runInstr(nop_i);

    $display("[TB] reset during a stall");
    runInstr(mk(0, 0, 4, 0, 0, 0, 1, 1, 0));
    applyStimulus(mk(4, 0, 5, 1, 0, 0, 1, 0, 0), 1'b0, s);
    applyStimulus(mk(4, 0, 5, 1, 0, 0, 1, 0, 0), 1'b1, s);
    runInstr(mk(4, 0, 5, 1, 0, 0, 1, 0, 0));
    repeat (3) runInstr(nop_i);

    $display("[TB] random traffic");
    for (int n = 0; n < 500; n++) begin
      runInstr(randInstr());
      if ($urandom_range(0, 99) == 0) begin
        applyStimulus(nop_i, 1'b1, s);
      end
    end

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expected entries left, want 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage ARM-subset pipeline (IF, ID, EX, MEM, WB).
- Tracks destination registers of in-flight instructions in a private shadow pipeline.
- Drives the PC enable, IF/ID enable and IF/ID clear, and the ID-stage control-mux select (bubble insertion).
- Drives operand forwarding selects for the EX stage.
- Resolves load-use stalls and ID-stage branch squashes.

Parameters:
- REG_W, 4, register index width.
- PC_REG, 15, register index never treated as a hazard source.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rn  in  REG_W  ID operand A register.
- id_rm  in  REG_W  ID operand B register.
- id_rd  in  REG_W  ID destination register; also the store-data source.
- id_use_rn  in  1  ID instruction reads rn.
- id_use_rm  in  1  ID instruction reads rm.
- id_use_rd  in  1  ID instruction reads rd (store data).
- id_rf_e  in  1  ID instruction writes rd (RF_E from ControlUnit).
- id_load  in  1  ID instruction is a load (ID_LOAD).
- id_branch_taken  in  1  branch/BL in ID resolved taken.
- pc_e  out  1  PC register enable.
- ifid_e  out  1  IF/ID register enable.
- ifid_clr  out  1  IF/ID synchronous clear (squash fetched instruction).
- ctrl_nop_s  out  1  1 = control mux drives all-zero controls into EX (bubble).
- fwd_a  out  2  operand A select: 00 RF, 01 EX result, 10 MEM result, 11 WB result.
- fwd_b  out  2  operand B select, same encoding.
- fwd_c  out  2  store-data select, same encoding.
- stall_cnt  out  CNT_W  count of stall cycles, saturating.

Behaviour:
- Shadow pipeline: three entries, EX, MEM and WB, each holding {valid, rd, rf_e, load}. All entries advance every clock.
  - EX entry loads the ID fields when no bubble is inserted.
  - EX entry loads valid=0 when a bubble is inserted (stall) or ifid_clr was asserted the previous cycle.
- Match rule: a source matches a stage when the stage is valid, rf_e=1, its rd equals the source, the use bit is set, and the source is not PC_REG.
- Load-use hazard: any source matches the EX stage with load=1.
  - Outputs: pc_e=0, ifid_e=0, ctrl_nop_s=1, ifid_clr=0.
  - Exactly 1 stall cycle; the next cycle the load sits in MEM and is forwarded via 10.
- Forwarding priority is EX > MEM > WB. No match gives 00. Selects are combinational from ID inputs and shadow state.
- Branch: id_branch_taken=1 and no stall gives ifid_clr=1 for that cycle, with pc_e=1 and ifid_e=1.
- Simultaneous stall and branch: stall wins, ifid_clr=0. The branch is re-evaluated next cycle because the instruction stays in ID.
- FSM states, registered:
  - RUN: no hazard.
  - STALL: hazard held this cycle.
  - SQUASH: a clear was issued the previous cycle.
  - Transitions: RUN→STALL on hazard; RUN→SQUASH on taken branch without hazard; STALL→RUN on no hazard; SQUASH→RUN or STALL by the same evaluation as RUN; any state→RUN on reset.
- stall_cnt increments by 1 each cycle with pc_e=0 and holds at all ones.
- Reset, sampled at clk:
  - State RUN, all shadow entries valid=0, stall_cnt=0.
  - While reset=1: pc_e=0, ifid_e=0, ifid_clr=1, ctrl_nop_s=1, fwd_*=00.
  - Reset during a stall abandons the stall; the first cycle after deassertion runs with a clean shadow pipeline.
- Idle: NOP (all-zero instruction, rf_e=0) never creates hazards.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- Defined: forwarding as above; only load-use hazards stall.
- Undefined:
  - fwd_a, fwd_b and fwd_c are tied to 00.
  - Any source matching EX, MEM or WB (any instruction type) causes a stall with the same outputs as a load-use stall.
  - Stall lasts until the producer has left WB, at most 3 cycles.
  - stall_cnt counts these stalls identically.

Decomposition:
- Shared package pipe_pkg holds:
  - FWD_RF, FWD_EX, FWD_MEM and FWD_WB encodings.
  - FSM state encodings ST_RUN, ST_STALL and ST_SQUASH.
  - PC_REG.
  - The shadow-entry struct type.
- One sub-module, hazard_match: combinational compare of one source against the three shadow entries. It returns a hit per stage and the priority forward select, and is instantiated three times (rn, rm, rd).

Test Plan:
- Reset held for 2 clocks, then released → pc_e=1, ifid_e=1, ctrl_nop_s=0, fwd_*=00, stall_cnt=0.
- ADD r1 then SUB r2,r1,r3 back-to-back → fwd_a=01 in the SUB's ID cycle, no stall. Without HAZARD_FWD_EN: 3 stall cycles, stall_cnt=3.
- LDR r4 then ADD r5,r4,r4 → one cycle pc_e=0, ctrl_nop_s=1; next cycle fwd_a=fwd_b=10; stall_cnt=1.
- STR r6 preceded two slots earlier by MOV r6 → fwd_c=10. Source r15 with a prior write to r15 → fwd=00, no stall.
- Taken B with no hazard → ifid_clr=1 for one cycle, state SQUASH; next EX shadow entry invalid. Taken B coincident with load-use → ifid_clr=0 during the stall, ifid_clr=1 the following cycle.
- Assert reset mid-stall (LDR r4 in EX, dependent in ID) → next cycle after release: no stall, all shadow entries invalid, stall_cnt=0.
